pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Parametrised match controller for the Pong game. It is the successor to the fixed 2-bit start/game/refill/end flow. It sequences serve, play, point and game-over. It keeps per-player scores and the remaining-ball count, and raises a rally-driven speed level. Its inputs are the ball engine's `collided`/`missed` levels and the joysticks' `isMoving`. It drives `restart` back into the ball engine, and drives scores and event pulses toward the 7-segment display and sound blocks.

## Interface
- `BALLS`, 3: balls per match, 1..15
- `WIN_SCORE`, 9: points that end the match immediately; must be < 2^`SCORE_W`
- `SCORE_W`, 4: width of each score register
- `SERVE_FRAMES`, 127: frames held between a point and the next serve, and also the game-over hold
- `RALLY_STEP`, 4: paddle hits per speed increment
- `MAX_SPEED`, 3: saturation value of `speed_lvl`
- `clk50M`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `endofframe`  in  1  frame-end level from graphics; the block edge-detects it internally
- `collided`  in  2  paddle-hit levels: bit0 = paddle one, bit1 = paddle two
- `missed`  in  2  wall-miss levels: bit0 = left wall, bit1 = right wall
- `isMoving`  in  1  OR of both joystick movement flags
- `restart`  out  1  holds the ball at centre while high
- `state`  out  3  current state encoding
- `score_one`, `score_two`  out  `SCORE_W`  player scores
- `balls_left`  out  4  balls remaining
- `speed_lvl`  out  2  ball speed level, 0..`MAX_SPEED`
- `serve_dir`  out  1  0 = serve toward the left player, 1 = toward the right
- `scored`  out  2  one-cycle point pulse: bit0 = player one scored, bit1 = player two scored
- `game_over`  out  1  high while in END
- `winner`  out  2  01 = player one, 10 = player two, 11 = tie; valid while `game_over` is high

## Operation
**Event detection**
- `frame` = `endofframe` & ~registered `endofframe`.
- Collision and miss events are per-bit rising edges: the level is compared against its value registered on the previous cycle.
- Events are acted on only in PLAY. Levels that persist for several cycles count once.

**States**
- IDLE (0)
  - `restart`=1; scores, `speed_lvl`, rally count and `winner` are cleared; `balls_left`=`BALLS`.
  - `isMoving`=1 → SERVE, timer loaded with `SERVE_FRAMES`.
- SERVE (1)
  - `restart`=1; the timer decrements on `frame`, saturating at 0.
  - Timer=0 and `isMoving`=1 → PLAY. If timer=0 and `isMoving`=0, the block waits in SERVE indefinitely.
- PLAY (2)
  - `restart`=0.
  - Each collide edge increments the rally count. When the count reaches `RALLY_STEP`, the count clears and `speed_lvl` increments, saturating at `MAX_SPEED`.
  - Both collide bits rising in the same cycle count as one hit.
  - Any miss edge → POINT, with the miss bits latched.
- POINT (3), one cycle
  - `restart`=1; `balls_left` decrements.
  - Latched missed=01 → `score_two`+1, `scored`=10, `serve_dir`=0.
  - Latched missed=10 → `score_one`+1, `scored`=01, `serve_dir`=1.
  - Latched missed=11 → no score change, `scored`=00, `serve_dir` unchanged; the ball is still consumed.
  - `speed_lvl` and the rally count clear.
  - A post-update score equal to `WIN_SCORE`, or post-update `balls_left`=0 → END, timer=`SERVE_FRAMES`. Otherwise → SERVE, timer=`SERVE_FRAMES`.
- END (4)
  - `restart`=1, `game_over`=1.
  - `winner` is the higher score, or 11 if the scores are equal.
  - The timer decrements on `frame`; timer=0 → IDLE.

**Width and arithmetic rules**
- Scores never exceed `WIN_SCORE`, so they never wrap.
- `balls_left` never decrements below 0.
- The timer is $clog2(`SERVE_FRAMES`+1) bits wide.
- Unused state encodings 5..7 → IDLE on the next clock.

## Timing
**Reset values:**
- `state`=IDLE, `restart`=1
- scores 0, `balls_left`=`BALLS`
- `speed_lvl`=0, `serve_dir`=0
- `scored`=00, `game_over`=0, `winner`=00
- edge-detect registers 0

**Latencies:**
- An `endofframe` rise is seen as `frame` 1 cycle later.
- Miss edge in PLAY → POINT on the next clock edge → score, `balls_left` and `scored` update on the following edge (2 cycles after the miss level rises) → `restart` high from the POINT cycle onward.
- `scored` is high for exactly 1 cycle.
- All outputs are registered. `restart` is decoded from the registered state and contains no combinational input path.
- Reset asserted mid-match returns every output to its reset value immediately (asynchronously). The first `isMoving` after reset release starts a fresh match.

## Test plan
- **Reset and idle:** hold `reset_n`=0, then release with `isMoving`=0 for 1000 cycles → `state`=0, `restart`=1, `balls_left`=3, scores 0.
- **Serve delay:** `isMoving`=1, `SERVE_FRAMES`=4, `endofframe` toggled every 20 cycles → PLAY entered exactly on the cycle after the 4th `frame` strobe; `restart` falls on that same cycle.
- **Point scoring:** in PLAY, hold `missed`=01 for 50 cycles → `score_two`=1 and `scored`=10 for one cycle; `balls_left`=2, `serve_dir`=0; only one point awarded.
- **Simultaneous miss:** `missed` goes 00→11 in PLAY → no score change, `balls_left` decrements, `scored`=00.
- **Rally speed:** 13 separate `collided` rises (bits alternating), `RALLY_STEP`=4 → `speed_lvl`=3, no wrap. A subsequent miss → `speed_lvl`=0.
- **Match end:**
  - `BALLS`=3, player one wins 2 points then player two wins 1 → END, `winner`=01, `game_over`=1; IDLE after the timer expires.
  - `WIN_SCORE`=2, player one wins 2 consecutive points → END with `balls_left`=1.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve, play, point and game-over, and keeps the scores,
// the remaining-ball budget and the rally-driven speed level.
module pong_match_ctrl #(
    parameter int BALLS        = 3,
    parameter int WIN_SCORE    = 9,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 127,
    parameter int RALLY_STEP   = 4,
    parameter int MAX_SPEED    = 3
) (
    input  logic               clk50M,
    input  logic               reset_n,
    input  logic               endofframe,
    input  logic [1:0]         collided,
    input  logic [1:0]         missed,
    input  logic               isMoving,
    output logic               restart,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score_one,
    output logic [SCORE_W-1:0] score_two,
    output logic [3:0]         balls_left,
    output logic [1:0]         speed_lvl,
    output logic               serve_dir,
    output logic [1:0]         scored,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int TIMER_W = $clog2(SERVE_FRAMES + 1);
    localparam int RALLY_W = $clog2(RALLY_STEP + 1);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [RALLY_W-1:0] RALLY_ZERO = {RALLY_W{1'b0}};
    localparam logic [RALLY_W-1:0] RALLY_ONE  = RALLY_W'(1);
    localparam logic [RALLY_W-1:0] RALLY_LAST = RALLY_W'(RALLY_STEP);
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [3:0]         BALLS_INIT = 4'(BALLS);
    localparam logic [1:0]         SPEED_MAX  = 2'(MAX_SPEED);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_END   = 3'd4
    } state_t;

    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    function automatic logic [1:0] pick_winner(input logic [SCORE_W-1:0] a,
                                               input logic [SCORE_W-1:0] b);
        return (a > b) ? 2'b01 : ((b > a) ? 2'b10 : 2'b11);
    endfunction

    state_t               state_r, state_s;
    logic                 eof_r;
    logic [1:0]           col_r, miss_r;
    logic [1:0]           miss_lat_r, miss_lat_s;
    logic [TIMER_W-1:0]   timer_r, timer_s, timer_dec_s;
    logic [RALLY_W-1:0]   rally_r, rally_s, rally_inc_s;
    logic [SCORE_W-1:0]   score_one_r, score_one_s, score_two_r, score_two_s;
    logic [SCORE_W-1:0]   pt_one_s, pt_two_s;
    logic [3:0]           balls_r, balls_s, pt_balls_s;
    logic [1:0]           speed_r, speed_s;
    logic                 dir_r, dir_s, pt_dir_s;
    logic [1:0]           scored_r, scored_s, pt_scored_s;
    logic                 game_over_r, game_over_s;
    logic [1:0]           winner_r, winner_s;
    logic                 restart_r, restart_s;
    logic                 frame_s, col_edge_s, pt_end_s;
    logic [1:0]           miss_edge_s;

    // Next-state and next-value logic for the match sequencer and its counters
    always_comb begin
        frame_s     = endofframe & ~eof_r;
        col_edge_s  = |(collided & ~col_r);
        miss_edge_s = missed & ~miss_r;
        timer_dec_s = (frame_s && (timer_r != TIMER_ZERO)) ? timer_r - TIMER_ONE : timer_r;
        rally_inc_s = rally_r + RALLY_ONE;

        // Outcome of the point being resolved, from the miss bits latched on entry to POINT
        pt_one_s    = score_one_r;
        pt_two_s    = score_two_r;
        pt_dir_s    = dir_r;
        pt_scored_s = 2'b00;
        case (miss_lat_r)
            2'b01: begin
                pt_two_s    = score_two_r + SCORE_ONE;
                pt_dir_s    = 1'b0;
                pt_scored_s = 2'b10;
            end
            2'b10: begin
                pt_one_s    = score_one_r + SCORE_ONE;
                pt_dir_s    = 1'b1;
                pt_scored_s = 2'b01;
            end
            default: begin
                pt_scored_s = 2'b00;
            end
        endcase
        pt_balls_s = sat_dec4(balls_r);
        pt_end_s   = (pt_one_s == SCORE_WIN) || (pt_two_s == SCORE_WIN) || (pt_balls_s == 4'd0);

        state_s     = state_r;
        timer_s     = timer_r;
        rally_s     = rally_r;
        score_one_s = score_one_r;
        score_two_s = score_two_r;
        balls_s     = balls_r;
        speed_s     = speed_r;
        dir_s       = dir_r;
        scored_s    = 2'b00;
        miss_lat_s  = miss_lat_r;
        winner_s    = winner_r;

        case (state_r)
            ST_IDLE: begin
                score_one_s = SCORE_ZERO;
                score_two_s = SCORE_ZERO;
                speed_s     = 2'd0;
                rally_s     = RALLY_ZERO;
                winner_s    = 2'b00;
                balls_s     = BALLS_INIT;
                if (isMoving) begin
                    state_s = ST_SERVE;
                    timer_s = TIMER_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                timer_s = timer_dec_s;
                if ((timer_dec_s == TIMER_ZERO) && isMoving) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (miss_edge_s != 2'b00) begin
                    state_s    = ST_POINT;
                    miss_lat_s = miss_edge_s;
                end else if (col_edge_s) begin
                    if (rally_inc_s == RALLY_LAST) begin
                        rally_s = RALLY_ZERO;
                        speed_s = (speed_r == SPEED_MAX) ? speed_r : speed_r + 2'd1;
                    end else begin
                        rally_s = rally_inc_s;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_POINT: begin
                score_one_s = pt_one_s;
                score_two_s = pt_two_s;
                balls_s     = pt_balls_s;
                dir_s       = pt_dir_s;
                scored_s    = pt_scored_s;
                speed_s     = 2'd0;
                rally_s     = RALLY_ZERO;
                timer_s     = TIMER_LOAD;
                if (pt_end_s) begin
                    state_s  = ST_END;
                    winner_s = pick_winner(pt_one_s, pt_two_s);
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_END: begin
                timer_s = timer_dec_s;
                if (timer_dec_s == TIMER_ZERO) begin
                    state_s  = ST_IDLE;
                    winner_s = 2'b00;
                end else begin
                    state_s = ST_END;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        game_over_s = (state_s == ST_END);
        restart_s   = (state_s != ST_PLAY);
    end

    // Sequencer state register
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Edge-detect history, match counters and registered outputs
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            eof_r       <= 1'b0;
            col_r       <= 2'b00;
            miss_r      <= 2'b00;
            miss_lat_r  <= 2'b00;
            timer_r     <= TIMER_ZERO;
            rally_r     <= RALLY_ZERO;
            score_one_r <= SCORE_ZERO;
            score_two_r <= SCORE_ZERO;
            balls_r     <= BALLS_INIT;
            speed_r     <= 2'd0;
            dir_r       <= 1'b0;
            scored_r    <= 2'b00;
            game_over_r <= 1'b0;
            winner_r    <= 2'b00;
            restart_r   <= 1'b1;
        end else begin
            eof_r       <= endofframe;
            col_r       <= collided;
            miss_r      <= missed;
            miss_lat_r  <= miss_lat_s;
            timer_r     <= timer_s;
            rally_r     <= rally_s;
            score_one_r <= score_one_s;
            score_two_r <= score_two_s;
            balls_r     <= balls_s;
            speed_r     <= speed_s;
            dir_r       <= dir_s;
            scored_r    <= scored_s;
            game_over_r <= game_over_s;
            winner_r    <= winner_s;
            restart_r   <= restart_s;
        end
    end

    assign state      = state_r;
    assign restart    = restart_r;
    assign score_one  = score_one_r;
    assign score_two  = score_two_r;
    assign balls_left = balls_r;
    assign speed_lvl  = speed_r;
    assign serve_dir  = dir_r;
    assign scored     = scored_r;
    assign game_over  = game_over_r;
    assign winner     = winner_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised match-level bench for pong_match_ctrl: point outcomes and winners are predicted
// from the game rules and consumed by a monitor that reacts to the DUT's point/game-over events.
module tb_pong_match_ctrl;

    localparam int BALLS        = 3;
    localparam int WIN_SCORE    = 2;
    localparam int SCORE_W      = 4;
    localparam int SERVE_FRAMES = 4;
    localparam int RALLY_STEP   = 4;
    localparam int MAX_SPEED    = 3;

    logic               clk50M = 1'b0;
    logic               reset_n = 1'b0;
    logic               endofframe = 1'b0;
    logic [1:0]         collided = 2'b00;
    logic [1:0]         missed = 2'b00;
    logic               isMoving = 1'b0;
    logic               restart;
    logic [2:0]         state;
    logic [SCORE_W-1:0] score_one, score_two;
    logic [3:0]         balls_left;
    logic [1:0]         speed_lvl;
    logic               serve_dir;
    logic [1:0]         scored;
    logic               game_over;
    logic [1:0]         winner;

    pong_match_ctrl #(
        .BALLS(BALLS), .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W),
        .SERVE_FRAMES(SERVE_FRAMES), .RALLY_STEP(RALLY_STEP), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clk50M(clk50M), .reset_n(reset_n), .endofframe(endofframe),
        .collided(collided), .missed(missed), .isMoving(isMoving),
        .restart(restart), .state(state), .score_one(score_one), .score_two(score_two),
        .balls_left(balls_left), .speed_lvl(speed_lvl), .serve_dir(serve_dir),
        .scored(scored), .game_over(game_over), .winner(winner)
    );

    always #5 clk50M = ~clk50M;

    typedef struct {
        int s1;
        int s2;
        int balls;
        int sc;
        int dir;
    } point_t;

    point_t pt_q[$];
    int     win_q[$];
    int     n_pass = 0;
    int     n_total = 0;
    int     m_s1, m_s2, m_balls, m_dir;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk50M);
        #1;
    endtask

    // Monitor: a drop in balls_left marks a resolved point, a game_over rise marks the match end
    initial begin : monitor
        logic [3:0] prev_balls;
        logic       prev_go;
        bit         pulse_chk;
        point_t     e;
        prev_balls = 4'(BALLS);
        prev_go    = 1'b0;
        pulse_chk  = 1'b0;
        forever begin
            @(negedge clk50M);
            if (!reset_n) begin
                prev_balls = 4'(BALLS);
                prev_go    = 1'b0;
                pulse_chk  = 1'b0;
            end else begin
                if (pulse_chk) begin
                    check("scored_width", int'(scored), 0);
                    pulse_chk = 1'b0;
                end
                if (balls_left < prev_balls) begin
                    if (pt_q.size() == 0) begin
                        n_total++;
                        $display("FAIL point_unexpected: actual balls_left %0d required no point", balls_left);
                    end else begin
                        e = pt_q.pop_front();
                        check("pt_score_one", int'(score_one), e.s1);
                        check("pt_score_two", int'(score_two), e.s2);
                        check("pt_balls", int'(balls_left), e.balls);
                        check("pt_scored", int'(scored), e.sc);
                        check("pt_serve_dir", int'(serve_dir), e.dir);
                        check("pt_speed_clr", int'(speed_lvl), 0);
                        check("pt_restart", int'(restart), 1);
                        pulse_chk = 1'b1;
                    end
                end
                if (game_over && !prev_go) begin
                    if (win_q.size() == 0) begin
                        n_total++;
                        $display("FAIL end_unexpected: actual winner %0d required no game over", winner);
                    end else begin
                        check("winner", int'(winner), win_q.pop_front());
                    end
                end
                prev_balls = balls_left;
                prev_go    = game_over;
            end
        end
    end

    // Four endofframe rises; the state must leave from_st exactly on the edge after the 4th strobe
    task automatic frames(input int from_st, input int to_st);
        int st;
        for (int f = 1; f <= SERVE_FRAMES; f++) begin
            endofframe = 1'b0;
            repeat ($urandom_range(2, 5)) step();
            endofframe = 1'b1;
            @(negedge clk50M);
            check("frame_pre_state", int'(state), from_st);
            step();
            @(negedge clk50M);
            st = (f == SERVE_FRAMES) ? to_st : from_st;
            check("frame_post_state", int'(state), st);
            check("frame_restart", int'(restart), (st == 2) ? 0 : 1);
            check("frame_game_over", int'(game_over), (st == 4) ? 1 : 0);
            repeat ($urandom_range(1, 3)) step();
        end
        endofframe = 1'b0;
        step();
    endtask

    task automatic play_point(input int hits, input logic [1:0] pat, input int hold, output bit ended);
        int es;
        logic [1:0] b;
        for (int i = 0; i < hits; i++) begin
            if ($urandom_range(0, 5) == 0) b = 2'b11;
            else b = (i % 2 == 0) ? 2'b01 : 2'b10;
            collided = b;
            repeat ($urandom_range(1, 4)) step();
            collided = 2'b00;
            repeat ($urandom_range(1, 3)) step();
        end
        es = hits / RALLY_STEP;
        if (es > MAX_SPEED) es = MAX_SPEED;
        @(negedge clk50M);
        check("rally_speed", int'(speed_lvl), es);
        check("play_state", int'(state), 2);
        check("play_restart", int'(restart), 0);
        step();
        missed = pat;
        m_balls = m_balls - 1;
        if (pat == 2'b01) begin
            m_s2++; m_dir = 0;
            pt_q.push_back('{s1: m_s1, s2: m_s2, balls: m_balls, sc: 2, dir: m_dir});
        end else if (pat == 2'b10) begin
            m_s1++; m_dir = 1;
            pt_q.push_back('{s1: m_s1, s2: m_s2, balls: m_balls, sc: 1, dir: m_dir});
        end else begin
            pt_q.push_back('{s1: m_s1, s2: m_s2, balls: m_balls, sc: 0, dir: m_dir});
        end
        ended = (m_s1 == WIN_SCORE) || (m_s2 == WIN_SCORE) || (m_balls == 0);
        if (ended) win_q.push_back((m_s1 > m_s2) ? 1 : ((m_s2 > m_s1) ? 2 : 3));
        @(negedge clk50M);
        check("miss_not_early", int'(state), 2);
        step();
        @(negedge clk50M);
        check("point_state", int'(state), 3);
        check("point_restart", int'(restart), 1);
        repeat (hold - 1) step();
        missed = 2'b00;
        @(negedge clk50M);
        check("after_point_state", int'(state), ended ? 4 : 1);
        check("after_point_game_over", int'(game_over), ended ? 1 : 0);
        step();
    endtask

    task automatic stall_serve();
        isMoving = 1'b0;
        frames(1, 1);
        repeat (10) step();
        @(negedge clk50M);
        check("stall_hold", int'(state), 1);
        step();
        isMoving = 1'b1;
        @(negedge clk50M);
        check("stall_before_move", int'(state), 1);
        step();
        @(negedge clk50M);
        check("stall_release_state", int'(state), 2);
        check("stall_release_restart", int'(restart), 0);
        step();
    endtask

    task automatic start_match();
        m_s1 = 0; m_s2 = 0; m_balls = BALLS;
        isMoving = 1'b1;
        @(negedge clk50M);
        check("start_idle", int'(state), 0);
        step();
        @(negedge clk50M);
        check("start_serve", int'(state), 1);
        check("start_balls", int'(balls_left), BALLS);
        step();
        frames(1, 2);
    endtask

    initial begin : stimulus
        bit         ended;
        int         hits, hold, k;
        logic [1:0] pat;
        m_dir = 0;
        repeat (3) step();
        @(negedge clk50M);
        check("rst_state", int'(state), 0);
        check("rst_restart", int'(restart), 1);
        check("rst_balls", int'(balls_left), BALLS);
        check("rst_scores", int'({score_one, score_two}), 0);
        check("rst_misc", int'({speed_lvl, serve_dir, scored, game_over, winner}), 0);
        step();
        reset_n = 1'b1;
        repeat (1000) step();
        @(negedge clk50M);
        check("idle_state", int'(state), 0);
        check("idle_restart", int'(restart), 1);
        check("idle_balls", int'(balls_left), BALLS);
        check("idle_scores", int'({score_one, score_two}), 0);
        step();

        for (int m = 0; m < 5; m++) begin
            start_match();
            ended = 1'b0;
            k = 0;
            while (!ended && k < BALLS) begin
                hits = $urandom_range(0, 13);
                hold = $urandom_range(2, 50);
                case ($urandom_range(0, 2))
                    0: pat = 2'b01;
                    1: pat = 2'b10;
                    default: pat = 2'b11;
                endcase
                if (m == 0 && k == 0) begin hits = 13; pat = 2'b01; hold = 50; end
                if (m == 0 && k == 1) pat = 2'b11;
                if (m == 2) pat = 2'b10;
                play_point(hits, pat, hold, ended);
                if (!ended) begin
                    if (m == 1 && k == 0) stall_serve();
                    else frames(1, 2);
                end
                k++;
            end
            check("match_ended", int'(ended), 1);
            isMoving = 1'b0;
            frames(4, 0);
            @(negedge clk50M);
            check("post_idle_scores", int'({score_one, score_two}), 0);
            check("post_idle_balls", int'(balls_left), BALLS);
            check("post_idle_flags", int'({speed_lvl, game_over, winner}), 0);
            check("post_idle_restart", int'(restart), 1);
            step();
        end

        // Asynchronous reset in the middle of a rally
        start_match();
        play_point(2, 2'b01, 5, ended);
        frames(1, 2);
        for (int i = 0; i < 5; i++) begin
            collided = 2'b01;
            step();
            collided = 2'b00;
            step();
        end
        @(negedge clk50M);
        check("pre_reset_speed", int'(speed_lvl), 1);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_restart", int'(restart), 1);
        check("async_balls", int'(balls_left), BALLS);
        check("async_scores", int'({score_one, score_two}), 0);
        check("async_misc", int'({speed_lvl, serve_dir, scored, game_over, winner}), 0);
        m_dir = 0;
        step();
        step();
        reset_n = 1'b1;
        @(negedge clk50M);
        check("release_idle", int'(state), 0);
        step();
        @(negedge clk50M);
        check("fresh_serve", int'(state), 1);
        check("fresh_balls", int'(balls_left), BALLS);

        check("pt_queue_drained", pt_q.size(), 0);
        check("win_queue_drained", win_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: actual time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
